// File: rtl/display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with frame-aligned update handshake.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scanner #(
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned GUARD_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] valor_i,
    input  logic        upd_req_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  digit_en_i,
    output logic        upd_done_o,
    output logic [3:0]  anodos_o,
    output logic [7:0]  segmentos_o
);

    localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    localparam logic [0:0] S_GUARD = 1'b0;
    localparam logic [0:0] S_ON    = 1'b1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [0:0]       state_q, state_d;

    logic [15:0] val_q, val_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  en_q, en_d;
    logic [15:0] sh_val_q, sh_val_d;
    logic [3:0]  sh_dp_q, sh_dp_d;
    logic [3:0]  sh_en_q, sh_en_d;
    logic        pend_q, pend_d;

    logic        done_q, done_d;
    logic [3:0]  anodos_q, anodos_d;
    logic [7:0]  seg_q, seg_d;

    logic        wrap;
    logic        commit;
    logic [3:0]  nib;
    logic [7:0]  dec;
    logic [3:0]  lz_blank;

    // Active-low abcdefg. pattern with the dp bit left dark
    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= S_GUARD;
            val_q    <= '0;
            dp_q     <= '0;
            en_q     <= '0;
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            sh_en_q  <= '0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            anodos_q <= 4'hF;
            seg_q    <= 8'hFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            val_q    <= val_d;
            dp_q     <= dp_d;
            en_q     <= en_d;
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            sh_en_q  <= sh_en_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            anodos_q <= anodos_d;
            seg_q    <= seg_d;
        end
    end

    // Slot timing and the guard/on state machine
    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        state_d = state_q;
        case (state_q)
            S_GUARD: if (cnt_q == GUARD_LAST) state_d = S_ON;
            S_ON:    if (wrap) state_d = S_GUARD;
            default: state_d = S_GUARD;
        endcase
    end

    // Shadow capture and frame-boundary commit; a request on the commit cycle survives for the next frame
    always_comb begin
        commit   = wrap && (idx_q == 2'd3) && pend_q;
        val_d    = commit ? sh_val_q : val_q;
        dp_d     = commit ? sh_dp_q  : dp_q;
        en_d     = commit ? sh_en_q  : en_q;
        sh_val_d = upd_req_i ? valor_i    : sh_val_q;
        sh_dp_d  = upd_req_i ? dp_i       : sh_dp_q;
        sh_en_d  = upd_req_i ? digit_en_i : sh_en_q;
        pend_d   = upd_req_i | (pend_q & ~commit);
        done_d   = commit;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A zero digit is blanked when every enabled digit above it is also zero
    always_comb begin
        logic hz;
        lz_blank = '0;
        hz       = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            lz_blank[k] = hz && (val_q[k*4 +: 4] == 4'h0);
            hz = hz && (!en_q[k] || (val_q[k*4 +: 4] == 4'h0));
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Output pattern for the current slot, registered
    always_comb begin
        nib      = val_q[{idx_q, 2'b00} +: 4];
        dec      = hex_seg(nib);
        anodos_d = 4'hF;
        seg_d    = 8'hFF;
        if (state_q == S_ON) begin
            anodos_d = ~(4'b0001 << idx_q);
            if (en_q[idx_q]) begin
                if (lz_blank[idx_q]) begin
                    seg_d = {7'h7F, ~dp_q[idx_q]};
                end else begin
                    seg_d = {dec[7:1], ~dp_q[idx_q]};
                end
            end
        end
    end

    assign upd_done_o  = done_q;
    assign anodos_o    = anodos_q;
    assign segmentos_o = seg_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: a per-cycle reference model pushes expected outputs, a monitor pops and compares.
module tb_display_scanner;

    localparam int unsigned SLOT  = 8;
    localparam int unsigned GUARD = 2;
    localparam int unsigned FRAME = 4 * SLOT;

    localparam logic [7:0] DEC [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       done;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] valor;
    logic        upd_req;
    logic [3:0]  dp;
    logic [3:0]  den;
    logic        upd_done;
    logic [3:0]  anodos;
    logic [7:0]  segmentos;

    obs_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    int unsigned edges = 0;
    logic [15:0] m_val = '0, s_val = '0;
    logic [3:0]  m_dp = '0, m_en = '0, s_dp = '0, s_en = '0;
    logic        m_pend = 1'b0;

    always #5 clk = ~clk;

    display_scanner #(.SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .valor_i     (valor),
        .upd_req_i   (upd_req),
        .dp_i        (dp),
        .digit_en_i  (den),
        .upd_done_o  (upd_done),
        .anodos_o    (anodos),
        .segmentos_o (segmentos)
    );

    function automatic logic [3:0] digit_of(input int k);
        return 4'(m_val >> (4 * k));
    endfunction

    function automatic logic lead_zero(input int k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k == 0 || digit_of(k) != 4'h0) return 1'b0;
        for (int j = k + 1; j < 4; j++)
            if (m_en[j] && digit_of(j) != 4'h0) return 1'b0;
        return 1'b1;
`else
        return (k < 0);
`endif
    endfunction

    // Display pattern for scan position p (cycles since reset release) using the committed frame
    function automatic obs_t pattern_at(input int unsigned p);
        obs_t        e;
        int          k;
        logic [7:0]  d;
        e.done = 1'b0;
        e.an   = 4'hF;
        e.seg  = 8'hFF;
        if (p % SLOT >= GUARD) begin
            k    = int'((p / SLOT) % 4);
            e.an = ~(4'b0001 << k);
            if (m_en[k]) begin
                d     = DEC[digit_of(k)];
                e.seg = lead_zero(k) ? {7'h7F, ~m_dp[k]} : {d[7:1], ~m_dp[k]};
            end
        end
        return e;
    endfunction

    // Reference model: one expectation per clock edge
    always @(posedge clk) begin
        obs_t e;
        if (!rst_n) begin
            edges  = 0;
            m_val  = '0; m_dp = '0; m_en = '0;
            s_val  = '0; s_dp = '0; s_en = '0;
            m_pend = 1'b0;
            e      = '{an: 4'hF, seg: 8'hFF, done: 1'b0};
        end else begin
            edges  = edges + 1;
            e      = pattern_at(edges - 1);
            e.done = (edges % FRAME == 0) && m_pend;
            if (e.done) begin
                m_val  = s_val; m_dp = s_dp; m_en = s_en;
                m_pend = 1'b0;
            end
            if (upd_req) begin
                s_val  = valor; s_dp = dp; s_en = den;
                m_pend = 1'b1;
            end
        end
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got an=%b seg=%h done=%b want an=%b seg=%h done=%b",
                     name, $time, got.an, got.seg, got.done, want.an, want.seg, want.done);
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scan", '{an: anodos, seg: segmentos, done: upd_done}, e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic req(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        valor   = v;
        dp      = d;
        den     = e;
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
    endtask

    task automatic wait_phase(input int unsigned ph);
        for (int i = 0; i < int'(2 * FRAME); i++) begin
            if (edges % FRAME == ph) return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_phase timeout got phase=%0d want %0d", edges % FRAME, ph);
    endtask

    initial begin
        rst_n   = 1'b0;
        valor   = '0;
        upd_req = 1'b0;
        dp      = '0;
        den     = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run(40);
        wait_phase(5);
        req(16'h12AF, 4'b0001, 4'b1111);
        run(2 * FRAME);

        wait_phase(3);
        req(16'h1111, 4'b0000, 4'b1111);
        wait_phase(10);
        req(16'h2222, 4'b0000, 4'b1111);
        run(2 * FRAME);

        wait_phase(7);
        req(16'h3C5A, 4'b1010, 4'b0101);
        run(2 * FRAME);

        wait_phase(8);
        req(16'hABCD, 4'b0000, 4'b1111);
        wait_phase(31);
        req(16'h5678, 4'b0110, 4'b1111);
        run(2 * FRAME + 4);

        wait_phase(2);
        req(16'h0040, 4'b0000, 4'b1111);
        run(2 * FRAME);
        wait_phase(2);
        req(16'h0040, 4'b1100, 4'b1111);
        run(2 * FRAME);
        wait_phase(2);
        req(16'h0300, 4'b0000, 4'b0111);
        run(2 * FRAME);

        wait_phase(4);
        req(16'h9999, 4'b1111, 4'b1111);
        wait_phase(20);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", '{an: anodos, seg: segmentos, done: upd_done},
               '{an: 4'hF, seg: 8'hFF, done: 1'b0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(3 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0)
                req(16'($urandom), 4'($urandom), 4'($urandom));
            else
                tick();
        end

        run(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
